conv_window_mac: RTL

- Stage directly downstream of the line buffer.
- Consumes one kernel_size x kernel_size pixel window and its matching filter, both flattened, and computes their signed dot product.
- Uses one serial multiply-accumulate per tap, with valid/ready handshakes on both sides.
- Emits one convolution output point per accepted window, to the feature-map writer.

---
 rtl/conv_window_mac.sv | 102 ++++++++++
 1 files changed

// File: rtl/conv_window_mac.sv
// Serial MAC over one kernel_size x kernel_size window: registers the window and
// filter on acceptance, accumulates one tap per cycle, then holds the result until taken.
module conv_window_mac #(
    parameter int kernel_size = 2,
    parameter int point_width = 8,
    parameter int acc_width   = 2*point_width + $clog2(kernel_size*kernel_size),
    parameter bit relu_en     = 1'b0
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [0:point_width*kernel_size*kernel_size-1] window,
    input  logic [0:point_width*kernel_size*kernel_size-1] filter,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic signed [acc_width-1:0]                     result,
    output logic                                            busy
);

    localparam int N      = kernel_size*kernel_size;
    localparam int TAP_W  = (N > 1) ? $clog2(N) : 1;
    localparam int PROD_W = 2*point_width;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                          state_q, state_d;
    logic signed [point_width-1:0]   win_taps [N];
    logic signed [point_width-1:0]   flt_taps [N];
    logic signed [point_width-1:0]   win_p0   [N];
    logic signed [point_width-1:0]   flt_p0   [N];
    logic        [TAP_W-1:0]         tap_p0;
    logic signed [acc_width-1:0]     acc_p0;
    logic signed [PROD_W-1:0]        prod;
    logic signed [acc_width-1:0]     acc_sum;
    logic                            accept;
    logic                            last_tap;

    function automatic logic signed [acc_width-1:0] relu(input logic signed [acc_width-1:0] x);
        if (relu_en && (x < 0))
            return '0;
        return x;
    endfunction

    // Tap 0 is the leftmost (most-significant) slice of each flattened vector.
    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign win_taps[g] = window[g*point_width +: point_width];
        assign flt_taps[g] = filter[g*point_width +: point_width];
    end

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MAC) || (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign last_tap  = (tap_p0 == TAP_W'(N-1));
    assign prod      = PROD_W'(win_p0[tap_p0]) * PROD_W'(flt_p0[tap_p0]);
    assign acc_sum   = acc_p0 + acc_width'(prod);

    always_ff @(posedge clock) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = MAC;
            MAC:     if (last_tap) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: operand capture; later input changes are ignored until the next accept.
    always_ff @(posedge clock) begin
        if (accept) begin
            win_p0 <= win_taps;
            flt_p0 <= flt_taps;
        end
    end

    // Accumulate one tap per MAC cycle; the result register is loaded on the final tap
    // so it is already stable when out_valid rises.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_p0 <= '0;
            tap_p0 <= '0;
            result <= '0;
        end else if (accept) begin
            acc_p0 <= '0;
            tap_p0 <= '0;
        end else if (state_q == MAC) begin
            acc_p0 <= acc_sum;
            tap_p0 <= tap_p0 + TAP_W'(1);
            if (last_tap)
                result <= relu(acc_sum);
        end
    end

endmodule
